// File: rtl/decoder_2to4_pkg.sv
// Shared types, idle constant and the 2-to-4 decode function for decoder_2to4.
package decoder_2to4_pkg;

  typedef logic [1:0] sel_t;
  typedef logic [3:0] onehot_t;

  localparam onehot_t ONEHOT_IDLE = 4'b0000;

  // Unknown select codes fall to the default and yield the idle word.
  function automatic onehot_t decode_2to4(sel_t sel);
    onehot_t word;
    case (sel)
      2'b00:   word = 4'b0001;
      2'b01:   word = 4'b0010;
      2'b10:   word = 4'b0100;
      2'b11:   word = 4'b1000;
      default: word = ONEHOT_IDLE;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational 2-to-4 one-hot decode; no clock, no polarity handling.
module decoder_2to4_core
  import decoder_2to4_pkg::*;
(
  input  sel_t    sel,
  output onehot_t onehot
);

  assign onehot = decode_2to4(sel);

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable, optional hold and output polarity.
// Define DECODER_2TO4_HOLD_EN to hold the previous word and valid on en=0 cycles.
module decoder_2to4
  import decoder_2to4_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] out,
  output logic       valid
);

  onehot_t w_onehot;
  onehot_t w_onehot_d;
  logic    w_valid_d;
  onehot_t r_onehot;
  logic    r_valid;

  decoder_2to4_core u_core (
    .sel    (sel),
    .onehot (w_onehot)
  );

  always_comb begin
    w_onehot_d = ONEHOT_IDLE;
    w_valid_d  = 1'b0;
    if (en) begin
      w_onehot_d = w_onehot;
      w_valid_d  = 1'b1;
    end
`ifdef DECODER_2TO4_HOLD_EN
    else begin
      w_onehot_d = r_onehot;
      w_valid_d  = r_valid;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot <= ONEHOT_IDLE;
      r_valid  <= 1'b0;
    end else begin
      r_onehot <= w_onehot_d;
      r_valid  <= w_valid_d;
    end
  end

  // Polarity is applied after the flop so reset shows as all-inactive in either mode.
  assign out   = ACTIVE_LOW ? ~r_onehot : r_onehot;
  assign valid = r_valid;

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: both polarities side by side against a reference model.
module tb_decoder_2to4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [3:0] out_h;
  logic [3:0] out_l;
  logic       valid_h;
  logic       valid_l;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference state: the logical (active-high) word and valid.
  logic [3:0] exp_word;
  logic       exp_valid;

  decoder_2to4 #(.ACTIVE_LOW(1'b0)) u_dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel),
    .out   (out_h),
    .valid (valid_h)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b1)) u_dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel),
    .out   (out_l),
    .valid (valid_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge, advance the model at the rising edge, return 1 ns later.
  task automatic apply(input logic a_en, input logic [1:0] a_sel);
    @(negedge clk);
    en  = a_en;
    sel = a_sel;
    @(posedge clk);
    if (a_en) begin
      exp_word  = 4'b0001 << a_sel;
      exp_valid = 1'b1;
    end else begin
`ifdef DECODER_2TO4_HOLD_EN
      exp_word  = exp_word;
      exp_valid = exp_valid;
`else
      exp_word  = 4'b0000;
      exp_valid = 1'b0;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    sel       = 2'b11;
    exp_word  = 4'b0000;
    exp_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_h !== 4'b0000 || valid_h !== 1'b0 || out_l !== 4'b1111 || valid_l !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d]: out=%b valid=%b out_al=%b valid_al=%b, expected 0000 0 1111 0",
                 i, out_h, valid_h, out_l, valid_l);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'b11);
    n_vec++;
    if (out_h !== 4'b1000 || valid_h !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: out=%b valid=%b, expected 1000 1", out_h, valid_h);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] want;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 2; c++) begin
        apply(1'b1, 2'(s));
        want = 4'b0001 << s;
        n_vec++;
        if (out_h !== want || valid_h !== 1'b1 || out_l !== ~want || valid_l !== 1'b1) begin
          n_err++;
          $display("FAIL sweep sel=%0d: out=%b valid=%b out_al=%b, expected %b 1 %b",
                   s, out_h, valid_h, out_l, want, ~want);
        end
      end
    end
  endtask

  task automatic test_enable_low();
    apply(1'b1, 2'b10);
    apply(1'b0, 2'b10);
    n_vec++;
`ifdef DECODER_2TO4_HOLD_EN
    if (out_h !== 4'b0100 || valid_h !== 1'b1) begin
      n_err++;
      $display("FAIL enable_low_hold: out=%b valid=%b, expected 0100 1", out_h, valid_h);
    end
`else
    if (out_h !== 4'b0000 || valid_h !== 1'b0 || out_l !== 4'b1111) begin
      n_err++;
      $display("FAIL enable_low: out=%b valid=%b out_al=%b, expected 0000 0 1111",
               out_h, valid_h, out_l);
    end
`endif
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 2'b01);
    n_vec++;
    if (out_h !== 4'b0010 || out_l !== 4'b1101) begin
      n_err++;
      $display("FAIL pre_reset: out=%b out_al=%b, expected 0010 1101", out_h, out_l);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_h !== 4'b0000 || valid_h !== 1'b0 || out_l !== 4'b1111 || valid_l !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: out=%b valid=%b out_al=%b valid_al=%b, expected 0000 0 1111 0",
               out_h, valid_h, out_l, valid_l);
    end
    exp_word  = 4'b0000;
    exp_valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [3];
    logic [3:0] want;
    seq[0] = 2'b00;
    seq[1] = 2'b11;
    seq[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, seq[i]);
      want = 4'b0001 << seq[i];
      n_vec++;
      if (out_h !== want || $countones(out_h) != 1 || out_l !== ~want) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: out=%b out_al=%b, expected %b %b",
                 i, out_h, out_l, want, ~want);
      end
    end
  endtask

  task automatic test_random();
    logic       r_en;
    logic [1:0] r_sel;
    for (int i = 0; i < 200; i++) begin
      r_en  = ($urandom_range(3, 0) != 0);
      r_sel = 2'($urandom_range(3, 0));
      apply(r_en, r_sel);
      // A mid-cycle select change must not disturb the registered output.
      if (i % 3 == 0) begin
        #2;
        sel = 2'($urandom_range(3, 0));
        #1;
      end
      n_vec++;
      if (out_h !== exp_word || valid_h !== exp_valid || out_l !== ~exp_word
          || valid_l !== exp_valid || (valid_h ? $countones(out_h) != 1 : out_h != 4'b0000)) begin
        n_err++;
        $display("FAIL random[%0d] en=%b sel=%b: out=%b valid=%b out_al=%b, expected %b %b %b",
                 i, r_en, r_sel, out_h, valid_h, out_l, exp_word, exp_valid, ~exp_word);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sweep();
    test_enable_low();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
